aurora_ll_tx_arbiter: RTL and testbench
=======================================

# aurora_ll_tx_arbiter

Shares the single Aurora 8B/10B LocalLink TX port (16-bit, 1-lane framing core) between NUM_REQ NoC router output streams. Arbitration is round-robin and frame-locked: a grant is held from SOF through EOF. The block also schedules clock compensation by generating WARN_CC/DO_CC for the core. It sits between the router egress ports and the core's TX_D/TX_REM/TX_SRC_RDY_N/TX_SOF_N/TX_EOF_N/TX_DST_RDY_N pins, in the USER_CLK domain.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CC_PERIOD, 5000, USER_CLK cycles per clock-compensation period
- WARN_LEN, 12, cycles WARN_CC is high before DO_CC
- DO_LEN, 6, cycles DO_CC is high

Ports:
- Clocking and reset: one clock, USER_CLK; reset is synchronous and active-high, RESET.
- USER_CLK  in  1  core user clock
- RESET  in  1  synchronous, active-high reset
- CHANNEL_UP  in  1  core channel status
- REQ_D  in  16*NUM_REQ  requester data; requester i uses [16i+15:16i]
- REQ_REM  in  NUM_REQ  requester remainder: 1 = both bytes valid
- REQ_SRC_RDY_N, REQ_SOF_N, REQ_EOF_N  in  NUM_REQ each  requester LocalLink controls, active-low
- REQ_DST_RDY_N  out  NUM_REQ  per-requester ready, active-low
- TX_D  out  16  to core
- TX_REM  out  1  to core
- TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N  out  1 each  to core
- TX_DST_RDY_N  in  1  core ready
- WARN_CC, DO_CC  out  1 each  to core CC inputs
- GRANT  out  NUM_REQ  one-hot current owner; 0 when idle
- BUSY  out  1  high while in LOCKED

## Operation
- FSM states:
  - IDLE: no owner.
  - LOCKED: GRANT[g]=1.
- Eligible requester i: REQ_SRC_RDY_N[i]=0, REQ_SOF_N[i]=0, and CHANNEL_UP=1.
- In IDLE with ≥1 eligible requester:
  - Pick the first eligible index searching from ptr upward, wrapping at NUM_REQ-1 → 0.
  - Register GRANT; go to LOCKED.
- Requesters presenting data without SOF while IDLE are not granted and not acknowledged.
- In LOCKED (owner g):
  - Datapath is combinational. TX_D, TX_REM, TX_SRC_RDY_N, TX_SOF_N and TX_EOF_N equal requester g's signals.
  - REQ_DST_RDY_N[g]=TX_DST_RDY_N; all other REQ_DST_RDY_N=1.
  - A beat transfers when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
  - A transfer with TX_EOF_N=0 moves the FSM to IDLE and sets ptr=(g+1) mod NUM_REQ. Single-beat frames (SOF and EOF together) are legal.
- When not LOCKED: TX_SRC_RDY_N=TX_SOF_N=TX_EOF_N=1, TX_D=0, TX_REM=0, all REQ_DST_RDY_N=1.
- CHANNEL_UP falls in LOCKED:
  - Next edge goes to IDLE, GRANT=0, ptr unchanged.
  - The truncated frame is abandoned; the requester restarts from SOF.
  - While CHANNEL_UP=0, TX_SRC_RDY_N is forced 1 combinationally.
- CC scheduler:
  - Free-running counter cc_cnt, 0..CC_PERIOD-1, wraps to 0; it runs regardless of CHANNEL_UP.
  - WARN_CC=1 when cc_cnt ∈ [CC_PERIOD-WARN_LEN-DO_LEN, CC_PERIOD-DO_LEN-1].
  - DO_CC=1 when cc_cnt ∈ [CC_PERIOD-DO_LEN, CC_PERIOD-1].
  - Both outputs are registered (decoded from next count), so they are never high together.
  - Counter width is ceil(log2(CC_PERIOD)).
  - The arbiter does not gate on CC; the core stalls via TX_DST_RDY_N.

## Timing
- Reset values:
  - State IDLE, ptr=0, cc_cnt=0.
  - GRANT=0, BUSY=0, WARN_CC=0, DO_CC=0.
  - TX_SRC_RDY_N=TX_SOF_N=TX_EOF_N=1, TX_D=0, TX_REM=0, REQ_DST_RDY_N all 1.
- Grant latency:
  - Eligible at edge N → GRANT/BUSY valid after edge N.
  - First beat can transfer at edge N+1.
- Frame gap: EOF transfers at edge M → IDLE after M; re-arbitration at M+1; next frame's first beat no earlier than M+2 (one bubble cycle).
- Simultaneous eligibility: round-robin guarantees each waiting requester is served within NUM_REQ frames.
- Owner stalls: if the owner raises SRC_RDY_N mid-frame, the grant is held indefinitely.
- RESET asserted mid-frame: all state returns to reset values at that edge; the partial frame is dropped.

## Test plan
- Reset, then requester 2 sends a 3-beat frame 0x1111, 0x2222, 0x3333 (EOF beat with REM=0), TX_DST_RDY_N=0 → GRANT=4'b0100 one cycle after SOF; TX_D follows in order; TX_REM=0 on the last beat; back to IDLE.
- All 4 requesters continuously present 2-beat frames, TX_DST_RDY_N=0 → grant order 0,1,2,3,0,…; exactly one idle cycle between frames; no beat lost or duplicated.
- TX_DST_RDY_N toggled randomly during a frame from requester 1 → REQ_DST_RDY_N[1] mirrors it; other REQ_DST_RDY_N stay 1; frame is intact.
- CHANNEL_UP dropped after beat 2 of a 5-beat frame → next edge GRANT=0 and TX_SRC_RDY_N=1; no grants while down; after CHANNEL_UP=1 with fresh SOF, a new grant follows using the unchanged ptr.
- CC_PERIOD=40, WARN_LEN=4, DO_LEN=2 → WARN_CC high at counts 34–37, DO_CC at 38–39; pattern repeats every 40 cycles; both 0 during reset.
- RESET asserted mid-frame while requester 3 is granted → GRANT=0, BUSY=0, ptr=0, cc_cnt=0 on the following cycle.

Source files
------------

// File: rtl/aurora_ll_tx_arbiter.sv
// aurora_ll_tx_arbiter
// Round-robin, frame-locked arbiter sharing one Aurora LocalLink TX port
// among NUM_REQ requesters, plus a free-running clock-compensation scheduler.
module aurora_ll_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CC_PERIOD = 5000,
    parameter int WARN_LEN  = 12,
    parameter int DO_LEN    = 6
) (
    input  logic                   USER_CLK,
    input  logic                   RESET,
    input  logic                   CHANNEL_UP,
    input  logic [16*NUM_REQ-1:0]  REQ_D,
    input  logic [NUM_REQ-1:0]     REQ_REM,
    input  logic [NUM_REQ-1:0]     REQ_SRC_RDY_N,
    input  logic [NUM_REQ-1:0]     REQ_SOF_N,
    input  logic [NUM_REQ-1:0]     REQ_EOF_N,
    output logic [NUM_REQ-1:0]     REQ_DST_RDY_N,
    output logic [15:0]            TX_D,
    output logic                   TX_REM,
    output logic                   TX_SRC_RDY_N,
    output logic                   TX_SOF_N,
    output logic                   TX_EOF_N,
    input  logic                   TX_DST_RDY_N,
    output logic                   WARN_CC,
    output logic                   DO_CC,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic                   BUSY
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CC_PERIOD - 1);
    localparam logic [CNT_W-1:0] WARN_LO   = CNT_W'(CC_PERIOD - WARN_LEN - DO_LEN);
    localparam logic [CNT_W-1:0] WARN_HI   = CNT_W'(CC_PERIOD - DO_LEN - 1);
    localparam logic [CNT_W-1:0] DO_LO     = CNT_W'(CC_PERIOD - DO_LEN);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [CNT_W-1:0]   cc_cnt_reg, cc_cnt_next;
    logic               warn_reg, do_reg;

    logic [15:0]        req_d_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   pick, cand;
    logic [IDX_W:0]     sum;
    logic               pick_valid;
    logic               locked;
    logic               beat_xfer;

    assign locked = (state_reg == ST_LOCKED);

    // Per-requester unpacking, eligibility and ready steering
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_d_arr[gi]     = REQ_D[16*gi +: 16];
            assign eligible[gi]      = CHANNEL_UP & ~REQ_SRC_RDY_N[gi] & ~REQ_SOF_N[gi];
            assign REQ_DST_RDY_N[gi] = (locked && owner_reg == IDX_W'(gi)) ? TX_DST_RDY_N : 1'b1;
        end
    endgenerate

    // Round-robin search: first eligible index at or after ptr, wrapping.
    // Scanning offsets from high to low lets the smallest offset win.
    always_comb begin
        pick       = ptr_reg;
        pick_valid = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum  = {1'b0, ptr_reg} + (IDX_W + 1)'(k);
            cand = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
            if (eligible[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Combinational datapath mux from the owner to the core; idle drives defaults
    always_comb begin
        TX_D         = '0;
        TX_REM       = 1'b0;
        TX_SRC_RDY_N = 1'b1;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        if (locked) begin
            TX_D         = req_d_arr[owner_reg];
            TX_REM       = REQ_REM[owner_reg];
            // A dead channel must never see a valid beat, even mid-frame
            TX_SRC_RDY_N = ~CHANNEL_UP | REQ_SRC_RDY_N[owner_reg];
            TX_SOF_N     = REQ_SOF_N[owner_reg];
            TX_EOF_N     = REQ_EOF_N[owner_reg];
        end
    end

    assign beat_xfer = ~TX_SRC_RDY_N & ~TX_DST_RDY_N;

    // Next-state logic: lock on SOF, release on EOF transfer or channel loss
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_LOCKED;
                    owner_next = pick;
                    grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                end
            end
            ST_LOCKED: begin
                if (!CHANNEL_UP) begin
                    // Abandon the frame; ptr stays so the same owner keeps priority
                    state_next = ST_IDLE;
                    grant_next = '0;
                end else if (beat_xfer && !TX_EOF_N) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
        end
    end

    assign cc_cnt_next = (cc_cnt_reg == CNT_LAST) ? '0 : cc_cnt_reg + CNT_W'(1);

    // Clock-compensation counter; flags decoded from the next count so they
    // line up with the registered count value
    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            cc_cnt_reg <= '0;
            warn_reg   <= 1'b0;
            do_reg     <= 1'b0;
        end else begin
            cc_cnt_reg <= cc_cnt_next;
            warn_reg   <= (cc_cnt_next >= WARN_LO) && (cc_cnt_next <= WARN_HI);
            do_reg     <= (cc_cnt_next >= DO_LO);
        end
    end

    assign GRANT   = grant_reg;
    assign BUSY    = locked;
    assign WARN_CC = warn_reg;
    assign DO_CC   = do_reg;

endmodule

// File: tb/tb_aurora_ll_tx_arbiter.sv
// tb_aurora_ll_tx_arbiter
// Table vectors, directed corner sequences and randomized traffic, all
// checked against a transaction-level reference model of the arbiter.
module tb_aurora_ll_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int CC_PERIOD = 40;
    localparam int WARN_LEN  = 4;
    localparam int DO_LEN    = 2;
    localparam int WARN_LO   = CC_PERIOD - WARN_LEN - DO_LEN;
    localparam int WARN_HI   = CC_PERIOD - DO_LEN - 1;
    localparam int DO_LO     = CC_PERIOD - DO_LEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, chan_up, tx_dst_n;
    logic [15:0]           rq_d [NUM_REQ];
    logic [NUM_REQ-1:0]    rq_rem, rq_src_n, rq_sof_n, rq_eof_n;
    logic [16*NUM_REQ-1:0] req_d_bus;
    logic [NUM_REQ-1:0]    dst_n, grant;
    logic [15:0]           tx_d;
    logic                  tx_rem, tx_src_n, tx_sof_n, tx_eof_n, warn, do_cc, busy;

    always_comb begin
        req_d_bus = '0;
        for (int i = 0; i < NUM_REQ; i++) req_d_bus[16*i +: 16] = rq_d[i];
    end

    aurora_ll_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .CC_PERIOD(CC_PERIOD), .WARN_LEN(WARN_LEN), .DO_LEN(DO_LEN)
    ) dut (
        .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(chan_up),
        .REQ_D(req_d_bus), .REQ_REM(rq_rem), .REQ_SRC_RDY_N(rq_src_n),
        .REQ_SOF_N(rq_sof_n), .REQ_EOF_N(rq_eof_n), .REQ_DST_RDY_N(dst_n),
        .TX_D(tx_d), .TX_REM(tx_rem), .TX_SRC_RDY_N(tx_src_n), .TX_SOF_N(tx_sof_n),
        .TX_EOF_N(tx_eof_n), .TX_DST_RDY_N(tx_dst_n),
        .WARN_CC(warn), .DO_CC(do_cc), .GRANT(grant), .BUSY(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = nobody), rotation pointer, cycles since reset
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cyc   = 0;

    // Requester traffic generators
    int s_on   [NUM_REQ];
    int s_beat [NUM_REQ];
    int s_len  [NUM_REQ];
    int s_seq  [NUM_REQ];
    int fixed_len = 2;
    int stall_pct = 0;
    int dst_pct   = 0;
    bit src_en    = 1'b1;

    logic [15:0]        obs [$];
    int                 order [$];
    int                 idle_cnt = 0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    typedef struct {
        logic        src_n, sof_n, eof_n, rem;
        logic [15:0] d;
        logic        dst;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic [15:0] e_d;
        logic        e_rem, e_src_n, e_sof_n, e_eof_n;
        logic [3:0]  e_dst;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] beat_data(input int r, input int seq, input int b);
        return 16'((r << 12) | ((seq & 255) << 4) | (b & 15));
    endfunction

    task automatic init_src(input int len);
        for (int i = 0; i < NUM_REQ; i++) begin
            s_beat[i] = 0;
            s_len[i]  = (len > 0) ? len : int'($urandom_range(1, 4));
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_src_n[i] = !(s_on[i] != 0 && !(stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct));
            rq_sof_n[i] = (s_beat[i] != 0);
            rq_eof_n[i] = (s_beat[i] != s_len[i] - 1);
            rq_d[i]     = beat_data(i, s_seq[i], s_beat[i]);
            rq_rem[i]   = (s_beat[i] == s_len[i] - 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        tx_dst_n = (dst_pct > 0 && int'($urandom_range(0, 99)) < dst_pct);
    endtask

    // Settle, then compare every DUT output against the model's view
    task automatic pre();
        logic [15:0]        e_d;
        logic               e_rem, e_src, e_sof, e_eof, e_warn, e_do;
        logic [NUM_REQ-1:0] e_dst, e_grant;
        int                 cc;
        #2;
        e_d = '0; e_rem = 1'b0; e_src = 1'b1; e_sof = 1'b1; e_eof = 1'b1;
        e_dst = '1; e_grant = '0;
        if (m_owner >= 0) begin
            e_d     = rq_d[m_owner];
            e_rem   = rq_rem[m_owner];
            e_src   = !(chan_up && !rq_src_n[m_owner]);
            e_sof   = rq_sof_n[m_owner];
            e_eof   = rq_eof_n[m_owner];
            e_dst[m_owner]   = tx_dst_n;
            e_grant[m_owner] = 1'b1;
        end
        cc     = m_cyc % CC_PERIOD;
        e_warn = (cc >= WARN_LO) && (cc <= WARN_HI);
        e_do   = (cc >= DO_LO);
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("tx_d", 32'(tx_d), 32'(e_d));
        chk("tx_rem", 32'(tx_rem), 32'(e_rem));
        chk("tx_src_rdy_n", 32'(tx_src_n), 32'(e_src));
        chk("tx_sof_n", 32'(tx_sof_n), 32'(e_sof));
        chk("tx_eof_n", 32'(tx_eof_n), 32'(e_eof));
        chk("req_dst_rdy_n", 32'(dst_n), 32'(e_dst));
        chk("warn_cc", 32'(warn), 32'(e_warn));
        chk("do_cc", 32'(do_cc), 32'(e_do));
        if (tx_src_n === 1'b0 && tx_dst_n === 1'b0) obs.push_back(tx_d);
        if (grant != 0 && prev_grant == 0)
            for (int i = 0; i < NUM_REQ; i++) if (grant[i]) order.push_back(i);
        prev_grant = grant;
        if (busy === 1'b0) idle_cnt++;
    endtask

    // Clock edge: advance the model and the traffic generators
    task automatic post();
        int  xfer, drop, k, i;
        bit  found;
        @(posedge clk);
        xfer = -1; drop = -1;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_owner < 0) begin
                found = 1'b0;
                if (chan_up)
                    for (k = 0; k < NUM_REQ; k++) begin
                        i = (m_ptr + k) % NUM_REQ;
                        if (!found && !rq_src_n[i] && !rq_sof_n[i]) begin
                            m_owner = i; found = 1'b1;
                        end
                    end
            end else if (!chan_up) begin
                drop = m_owner; m_owner = -1;
            end else if (!rq_src_n[m_owner] && !tx_dst_n) begin
                xfer = m_owner;
                if (!rq_eof_n[m_owner]) begin
                    m_ptr = (m_owner + 1) % NUM_REQ; m_owner = -1;
                end
            end
        end
        if (rst) begin
            for (int j = 0; j < NUM_REQ; j++) s_beat[j] = 0;
        end else if (src_en) begin
            if (drop >= 0) s_beat[drop] = 0;
            if (xfer >= 0) begin
                s_beat[xfer]++;
                if (s_beat[xfer] == s_len[xfer]) begin
                    s_beat[xfer] = 0;
                    s_seq[xfer]++;
                    s_len[xfer] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
                end
            end
        end
        #1;
    endtask

    task automatic cycle();
        if (src_en) drive_sources();
        pre();
        post();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) cycle();
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_warn", 32'(warn), 32'(0));
        chk("rst_do", 32'(do_cc), 32'(0));
        chk("rst_src_rdy_n", 32'(tx_src_n), 32'(1));
        chk("rst_dst_rdy_n", 32'(dst_n), 32'(4'hF));
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq0, c, sp, down;
        rst = 1'b1; chan_up = 1'b1; tx_dst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_on[i] = 0; s_seq[i] = 0;
        end
        init_src(2);
        drive_sources();
        @(posedge clk); #1;
        do_reset(3);

        // Single 3-beat frame from requester 2, table driven
        vt[0] = '{1'b0,1'b0,1'b1,1'b1,16'h1111,1'b0, 4'b0000,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b1,4'b1111};
        vt[1] = '{1'b0,1'b0,1'b1,1'b1,16'h1111,1'b0, 4'b0100,1'b1,16'h1111,1'b1,1'b0,1'b0,1'b1,4'b1011};
        vt[2] = '{1'b0,1'b1,1'b1,1'b1,16'h2222,1'b0, 4'b0100,1'b1,16'h2222,1'b1,1'b0,1'b1,1'b1,4'b1011};
        vt[3] = '{1'b0,1'b1,1'b0,1'b0,16'h3333,1'b0, 4'b0100,1'b1,16'h3333,1'b0,1'b0,1'b1,1'b0,4'b1011};
        vt[4] = '{1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0, 4'b0000,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b1,4'b1111};
        vt[5] = '{1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0, 4'b0000,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b1,4'b1111};
        src_en = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rq_src_n[i] = 1'b1; rq_sof_n[i] = 1'b1; rq_eof_n[i] = 1'b1;
                rq_d[i] = '0; rq_rem[i] = 1'b0;
            end
            rq_src_n[2] = vt[r].src_n; rq_sof_n[2] = vt[r].sof_n; rq_eof_n[2] = vt[r].eof_n;
            rq_rem[2] = vt[r].rem; rq_d[2] = vt[r].d; tx_dst_n = vt[r].dst;
            pre();
            chk("t1_grant", 32'(grant), 32'(vt[r].e_grant));
            chk("t1_busy", 32'(busy), 32'(vt[r].e_busy));
            chk("t1_tx_d", 32'(tx_d), 32'(vt[r].e_d));
            chk("t1_tx_rem", 32'(tx_rem), 32'(vt[r].e_rem));
            chk("t1_ctrl", 32'({tx_src_n, tx_sof_n, tx_eof_n}),
                32'({vt[r].e_src_n, vt[r].e_sof_n, vt[r].e_eof_n}));
            chk("t1_dst_rdy", 32'(dst_n), 32'(vt[r].e_dst));
            post();
        end
        src_en = 1'b1;

        // All requesters stream 2-beat frames back to back
        do_reset(2);
        fixed_len = 2; init_src(2);
        for (int i = 0; i < NUM_REQ; i++) begin s_on[i] = 1; s_seq[i] = 0; end
        obs.delete(); order.delete(); idle_cnt = 0; prev_grant = '0;
        for (int n = 0; n < 24; n++) cycle();
        for (int i = 0; i < NUM_REQ; i++) s_on[i] = 0;
        chk("t2_idle_cycles", 32'(idle_cnt), 32'(8));
        chk("t2_beats", 32'(obs.size()), 32'(16));
        chk("t2_frames", 32'(order.size()), 32'(8));
        for (int f = 0; f < 8; f++) begin
            if (f < order.size()) chk("t2_order", 32'(order[f]), 32'(f % NUM_REQ));
            for (int b = 0; b < 2; b++)
                if (2*f + b < obs.size())
                    chk("t2_data", 32'(obs[2*f+b]), 32'(beat_data(f % NUM_REQ, f / NUM_REQ, b)));
        end

        // Requester 1 frame with a randomly stalling core
        do_reset(1);
        fixed_len = 6; init_src(6);
        s_on[1] = 1; dst_pct = 50; seq0 = s_seq[1]; obs.delete();
        for (c = 0; c < 200 && s_seq[1] == seq0; c++) cycle();
        s_on[1] = 0; dst_pct = 0;
        chk("t3_frame_done", 32'(s_seq[1] != seq0), 32'(1));
        chk("t3_beats", 32'(obs.size()), 32'(6));
        for (int b = 0; b < 6; b++)
            if (b < obs.size()) chk("t3_data", 32'(obs[b]), 32'(beat_data(1, seq0, b)));

        // Channel loss after beat 2 of a 5-beat frame
        fixed_len = 5; init_src(5); s_on[1] = 1;
        for (c = 0; c < 50 && s_beat[1] != 2; c++) cycle();
        chk("t4_reached_beat2", 32'(s_beat[1]), 32'(2));
        sp = m_ptr;
        chan_up = 1'b0;
        drive_sources(); pre();
        chk("t4_src_forced", 32'(tx_src_n), 32'(1));
        post();
        for (int n = 0; n < 3; n++) begin
            drive_sources(); pre();
            chk("t4_down_grant", 32'(grant), 32'(0));
            chk("t4_down_src", 32'(tx_src_n), 32'(1));
            post();
        end
        chan_up = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) s_on[i] = 1;
        cycle();
        chk("t4_regrant", 32'(grant), 32'(1 << sp));
        for (int i = 0; i < NUM_REQ; i++) s_on[i] = 0;

        // Reset in the middle of a requester-3 frame
        do_reset(1);
        fixed_len = 2; init_src(2); s_on[1] = 1; seq0 = s_seq[1];
        for (c = 0; c < 20 && s_seq[1] == seq0; c++) cycle();
        s_on[1] = 0; fixed_len = 6; s_len[3] = 6; s_beat[3] = 0; s_on[3] = 1;
        for (c = 0; c < 20 && s_beat[3] != 2; c++) cycle();
        chk("t5_owner3", 32'(grant), 32'(4'b1000));
        rst = 1'b1; cycle();
        chk("t5_rst_grant", 32'(grant), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_cc", 32'({warn, do_cc}), 32'(0));
        rst = 1'b0; s_on[3] = 0; init_src(2); s_on[1] = 1; s_on[2] = 1;
        cycle();
        chk("t5_ptr_cleared", 32'(grant), 32'(4'b0010));
        s_on[1] = 0; s_on[2] = 0;

        // Clock-compensation pattern over two periods
        do_reset(2);
        for (int k = 0; k < 85; k++) begin
            drive_sources(); pre();
            chk("t6_warn", 32'(warn), 32'((k % CC_PERIOD) >= 34 && (k % CC_PERIOD) <= 37));
            chk("t6_do", 32'(do_cc), 32'((k % CC_PERIOD) >= 38));
            post();
        end

        // Randomized traffic, stalls and channel drops
        do_reset(1);
        fixed_len = 0; init_src(0); stall_pct = 20; dst_pct = 30; down = 0;
        for (int i = 0; i < NUM_REQ; i++) s_on[i] = 1;
        for (int n = 0; n < 1500; n++) begin
            if (down > 0) begin
                down--; chan_up = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                down = int'($urandom_range(1, 5)); chan_up = 1'b0;
            end else begin
                chan_up = 1'b1;
            end
            cycle();
        end
        chan_up = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
